// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: trap FSM, redirects, load-use and structural stalls.
// Optional performance counters are built only when HAZARD_SCOREBOARD_PERF_EN is defined.
module hazard_scoreboard #(
  parameter int NUM_STAGES   = 4,
  parameter int LOAD_LATENCY = 1,
  parameter int MAX_LOADS    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stallControl,
  input  logic                  fetchDecodeValid,
  input  logic                  decodeExecuteValid,
  input  logic                  memoryWritebackValid,
  input  logic [4:0]            readAddress1,
  input  logic [4:0]            readAddress2,
  input  logic                  decodeExecuteIsLoad,
  input  logic [4:0]            decodeExecuteDestinationRegister,
  input  logic                  branchValid,
  input  logic                  mretSignal,
  input  logic                  trapValid,
  input  logic [3:0]            trapCause,
  input  logic [31:0]           trapValue,
  output logic [NUM_STAGES-1:0] stageStall,
  output logic [NUM_STAGES-1:0] stageFlush,
  output logic                  controlReset,
  output logic [3:0]            mcause,
  output logic [31:0]           mtval,
  output logic                  trapTaken,
  output logic [31:0]           loadUseStallCount,
  output logic [31:0]           structStallCount
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  localparam logic [2:0] LAT = 3'(LOAD_LATENCY);

  state_t          state_reg;
  logic            trap_taken_reg;
  logic [3:0]      mcause_reg;
  logic [31:0]     mtval_reg;

  logic [MAX_LOADS-1:0] ent_valid_reg;
  logic [4:0]           ent_rd_reg    [MAX_LOADS];
  logic [2:0]           ent_count_reg [MAX_LOADS];

  logic [MAX_LOADS-1:0] ent_expire;
  logic [MAX_LOADS-1:0] ent_free;
  logic [MAX_LOADS-1:0] ent_match;
  logic [MAX_LOADS-1:0] alloc_onehot;

  logic run;
  logic trap_accept;
  logic redirect;
  logic rs1_nz;
  logic rs2_nz;
  logic alloc_req;
  logic alloc_match;
  logic load_use;
  logic struct_hz;
  logic alloc_fire;

  assign run         = (state_reg == RUN);
  assign trap_accept = !reset && run && trapValid && memoryWritebackValid;
  assign redirect    = run && !trap_accept && (branchValid || mretSignal);
  assign rs1_nz      = (readAddress1 != 5'd0);
  assign rs2_nz      = (readAddress2 != 5'd0);

  // Loads arriving while in TRAP are discarded, so they never request a slot.
  assign alloc_req   = run && decodeExecuteValid && decodeExecuteIsLoad &&
                       (decodeExecuteDestinationRegister != 5'd0);
  assign alloc_match = alloc_req &&
                       ((rs1_nz && decodeExecuteDestinationRegister == readAddress1) ||
                        (rs2_nz && decodeExecuteDestinationRegister == readAddress2));

  generate
    for (genvar gi = 0; gi < MAX_LOADS; gi++) begin : g_entry
      // An entry whose count reaches zero this edge is reusable by a load in the same cycle.
      assign ent_expire[gi] = ent_valid_reg[gi] && !stallControl && (ent_count_reg[gi] == 3'd1);
      assign ent_free[gi]   = !ent_valid_reg[gi] || ent_expire[gi];
      assign ent_match[gi]  = ent_valid_reg[gi] &&
                              ((rs1_nz && ent_rd_reg[gi] == readAddress1) ||
                               (rs2_nz && ent_rd_reg[gi] == readAddress2));
    end
  endgenerate

  assign alloc_onehot = ent_free & ~(ent_free - MAX_LOADS'(1));

  assign load_use   = run && !trap_accept && fetchDecodeValid && (alloc_match || (|ent_match));
  assign struct_hz  = run && !trap_accept && alloc_req && !(|ent_free);
  // The load-use bubble flush of stage 1 lets the load advance, so it does not block allocation.
  assign alloc_fire = alloc_req && !trap_accept && !stallControl && !struct_hz &&
                      !redirect && (|ent_free);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= RUN;
      trap_taken_reg <= 1'b0;
      mcause_reg     <= 4'd0;
      mtval_reg      <= 32'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (trap_accept) begin
            state_reg      <= TRAP;
            trap_taken_reg <= 1'b1;
            mcause_reg     <= trapCause;
            mtval_reg      <= trapValue;
          end
        end
        TRAP: begin
          state_reg      <= RUN;
          trap_taken_reg <= 1'b0;
        end
        default: begin
          state_reg      <= RUN;
          trap_taken_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MAX_LOADS; i++) begin
        ent_valid_reg[i] <= 1'b0;
        ent_rd_reg[i]    <= 5'd0;
        ent_count_reg[i] <= 3'd0;
      end
    end else if (trap_accept) begin
      ent_valid_reg <= '0;
    end else begin
      for (int i = 0; i < MAX_LOADS; i++) begin
        if (alloc_fire && alloc_onehot[i]) begin
          ent_valid_reg[i] <= 1'b1;
          ent_rd_reg[i]    <= decodeExecuteDestinationRegister;
          ent_count_reg[i] <= LAT;
        end else if (ent_valid_reg[i] && !stallControl) begin
          ent_count_reg[i] <= ent_count_reg[i] - 3'd1;
          if (ent_count_reg[i] == 3'd1) begin
            ent_valid_reg[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    stageStall   = '0;
    stageFlush   = '0;
    controlReset = 1'b0;
    if (reset) begin
      stageStall = '0;
    end else if (trap_accept) begin
      stageFlush   = '1;
      controlReset = 1'b1;
    end else if (state_reg == TRAP) begin
      stageFlush = '1;
    end else begin
      if (redirect) begin
        stageFlush[1:0] = 2'b11;
      end
      if (stallControl) begin
        stageStall = '1;
      end
      if (struct_hz) begin
        stageStall[1:0] = 2'b11;
      end
      // A held stage 1 must not be bubbled, so the load-use flush yields to any stage-1 stall.
      if (load_use) begin
        stageStall[0] = 1'b1;
        if (!stallControl && !struct_hz) begin
          stageFlush[1] = 1'b1;
        end
      end
    end
  end

  assign trapTaken = trap_taken_reg && !reset;
  assign mcause    = mcause_reg;
  assign mtval     = mtval_reg;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] load_use_cnt_reg;
  logic [31:0] struct_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      load_use_cnt_reg <= 32'd0;
      struct_cnt_reg   <= 32'd0;
    end else begin
      if (load_use) begin
        load_use_cnt_reg <= load_use_cnt_reg + 32'd1;
      end
      if (struct_hz) begin
        struct_cnt_reg <= struct_cnt_reg + 32'd1;
      end
    end
  end

  assign loadUseStallCount = load_use_cnt_reg;
  assign structStallCount  = struct_cnt_reg;
`else
  assign loadUseStallCount = 32'd0;
  assign structStallCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; three instances share stimulus to cover
// the default, long-latency and single-entry configurations.
module tb_hazard_scoreboard;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, stallControl, fetchDecodeValid, decodeExecuteValid, memoryWritebackValid;
  logic [4:0]  readAddress1, readAddress2, decodeExecuteDestinationRegister;
  logic        decodeExecuteIsLoad, branchValid, mretSignal, trapValid;
  logic [3:0]  trapCause;
  logic [31:0] trapValue;

  logic [3:0]  st1, fl1, st2, fl2, st3, fl3;
  logic        cr1, cr2, cr3, tt1, tt2, tt3;
  logic [3:0]  mc1, mc2, mc3;
  logic [31:0] mt1, mt2, mt3, lu1, lu2, lu3, sc1, sc2, sc3;

  int checks = 0;
  int errors = 0;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  localparam logic [31:0] PERF_ONE = 32'd1;
`else
  localparam logic [31:0] PERF_ONE = 32'd0;
`endif

  // LOAD_LATENCY=3 expectations across a two-cycle external stall.
  logic       b_sc [0:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] b_st [0:6] = '{4'h1, 4'h1, 4'hF, 4'hF, 4'h1, 4'h1, 4'h0};
  logic [3:0] b_fl [0:6] = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};

  hazard_scoreboard dut (
    .clock(clock), .reset(reset), .stallControl(stallControl),
    .fetchDecodeValid(fetchDecodeValid), .decodeExecuteValid(decodeExecuteValid),
    .memoryWritebackValid(memoryWritebackValid),
    .readAddress1(readAddress1), .readAddress2(readAddress2),
    .decodeExecuteIsLoad(decodeExecuteIsLoad),
    .decodeExecuteDestinationRegister(decodeExecuteDestinationRegister),
    .branchValid(branchValid), .mretSignal(mretSignal), .trapValid(trapValid),
    .trapCause(trapCause), .trapValue(trapValue),
    .stageStall(st1), .stageFlush(fl1), .controlReset(cr1), .mcause(mc1), .mtval(mt1),
    .trapTaken(tt1), .loadUseStallCount(lu1), .structStallCount(sc1)
  );

  hazard_scoreboard #(.NUM_STAGES(4), .LOAD_LATENCY(3), .MAX_LOADS(2)) dut_lat3 (
    .clock(clock), .reset(reset), .stallControl(stallControl),
    .fetchDecodeValid(fetchDecodeValid), .decodeExecuteValid(decodeExecuteValid),
    .memoryWritebackValid(memoryWritebackValid),
    .readAddress1(readAddress1), .readAddress2(readAddress2),
    .decodeExecuteIsLoad(decodeExecuteIsLoad),
    .decodeExecuteDestinationRegister(decodeExecuteDestinationRegister),
    .branchValid(branchValid), .mretSignal(mretSignal), .trapValid(trapValid),
    .trapCause(trapCause), .trapValue(trapValue),
    .stageStall(st2), .stageFlush(fl2), .controlReset(cr2), .mcause(mc2), .mtval(mt2),
    .trapTaken(tt2), .loadUseStallCount(lu2), .structStallCount(sc2)
  );

  hazard_scoreboard #(.NUM_STAGES(4), .LOAD_LATENCY(2), .MAX_LOADS(1)) dut_one (
    .clock(clock), .reset(reset), .stallControl(stallControl),
    .fetchDecodeValid(fetchDecodeValid), .decodeExecuteValid(decodeExecuteValid),
    .memoryWritebackValid(memoryWritebackValid),
    .readAddress1(readAddress1), .readAddress2(readAddress2),
    .decodeExecuteIsLoad(decodeExecuteIsLoad),
    .decodeExecuteDestinationRegister(decodeExecuteDestinationRegister),
    .branchValid(branchValid), .mretSignal(mretSignal), .trapValid(trapValid),
    .trapCause(trapCause), .trapValue(trapValue),
    .stageStall(st3), .stageFlush(fl3), .controlReset(cr3), .mcause(mc3), .mtval(mt3),
    .trapTaken(tt3), .loadUseStallCount(lu3), .structStallCount(sc3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stallControl = 0; fetchDecodeValid = 0; decodeExecuteValid = 0; memoryWritebackValid = 0;
    readAddress1 = 0; readAddress2 = 0; decodeExecuteIsLoad = 0;
    decodeExecuteDestinationRegister = 0; branchValid = 0; mretSignal = 0; trapValid = 0;
    trapCause = 0; trapValue = 0;
  endtask

  task automatic load(input logic [4:0] rd);
    decodeExecuteValid = 1; decodeExecuteIsLoad = 1; decodeExecuteDestinationRegister = rd;
  endtask

  task automatic settle(input string name);
    #1;
    $display("%-8s t=%0t st=%b/%b/%b fl=%b/%b/%b cr=%b tt=%b mcause=%0h mtval=%0h",
             name, $time, st1, st2, st3, fl1, fl2, fl3, cr1, tt1, mc1, mt1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; idle(); tick(); reset = 0;
  endtask

  initial begin
    // Reset with every request asserted: all controls must stay low.
    reset = 1; idle();
    trapValid = 1; memoryWritebackValid = 1; branchValid = 1; stallControl = 1;
    fetchDecodeValid = 1; readAddress1 = 5'd5; load(5'd5);
    settle("rst0");
    check("rst_stall", st1, 4'h0); check("rst_flush", fl1, 4'h0);
    check("rst_ctrlrst", cr1, 1'b0); check("rst_taken", tt1, 1'b0);
    tick();
    settle("rst1");
    check("rst_mcause", mc1, 4'h0); check("rst_mtval", mt1, 32'h0);
    check("rst_lu_cnt", lu1, 32'h0); check("rst_st_cnt", sc1, 32'h0);
    check("rst_flush1", fl1, 4'h0); check("rst_taken1", tt1, 1'b0);
    do_reset();

    // Load-use with LOAD_LATENCY=1: two stall cycles then release.
    idle(); load(5'd5); fetchDecodeValid = 1; readAddress1 = 5'd5;
    settle("lu0");
    check("lu_c0_stall", st1, 4'h1); check("lu_c0_flush", fl1, 4'h2);
    tick();
    idle(); fetchDecodeValid = 1; readAddress1 = 5'd5;
    settle("lu1");
    check("lu_c1_stall", st1, 4'h1); check("lu_c1_flush", fl1, 4'h2);
    tick();
    settle("lu2");
    check("lu_c2_stall", st1, 4'h0); check("lu_c2_flush", fl1, 4'h0);
    do_reset();

    // LOAD_LATENCY=3 with external stall mid-countdown: 4+2 stalled cycles.
    for (int i = 0; i < 7; i++) begin
      idle(); fetchDecodeValid = 1; readAddress2 = 5'd5; stallControl = b_sc[i];
      if (i == 0) load(5'd5);
      settle($sformatf("lat3_%0d", i));
      check($sformatf("lat3_c%0d_stall", i), st2, b_st[i]);
      check($sformatf("lat3_c%0d_flush", i), fl2, b_fl[i]);
      tick();
    end
    do_reset();

    // Single entry, back-to-back loads x6, x7: one structural stall cycle.
    idle(); load(5'd6);
    settle("st0");
    check("struct_c0_stall", st3, 4'h0);
    tick();
    idle(); load(5'd7);
    settle("st1");
    check("struct_c1_stall", st3, 4'h3); check("struct_c1_flush", fl3, 4'h0);
    tick();
    idle(); load(5'd7);
    settle("st2");
    check("struct_c2_stall", st3, 4'h0);
    tick();
    idle(); fetchDecodeValid = 1; readAddress1 = 5'd7;
    settle("st3");
    check("struct_x7_alloc", st3, 4'h1);
    check("struct_cnt", sc3, PERF_ONE); check("lu_cnt_pre", lu3, 32'h0);
    tick();
    idle();
    settle("st4");
    check("lu_cnt_post", lu3, PERF_ONE); check("struct_cnt_hold", sc3, PERF_ONE);
    do_reset();

    // Trap accepted during external stall; scoreboard cleared, TRAP ignores requests.
    idle(); load(5'd9);
    settle("tr0");
    tick();
    idle(); trapValid = 1; memoryWritebackValid = 1; trapCause = 4'h2; trapValue = 32'hDEAD_BEEF;
    stallControl = 1; fetchDecodeValid = 1; readAddress1 = 5'd9; branchValid = 1;
    settle("tr1");
    check("trap_acc_stall", st1, 4'h0); check("trap_acc_flush", fl1, 4'hF);
    check("trap_acc_ctrlrst", cr1, 1'b1); check("trap_acc_taken", tt1, 1'b0);
    check("trap_acc_stall_l3", st2, 4'h0); check("trap_acc_flush_l3", fl2, 4'hF);
    tick();
    idle(); trapValid = 1; memoryWritebackValid = 1; trapCause = 4'h5; trapValue = 32'h1234;
    load(5'd10); fetchDecodeValid = 1; readAddress1 = 5'd9;
    settle("tr2");
    check("trap_st_flush", fl1, 4'hF); check("trap_st_stall", st1, 4'h0);
    check("trap_st_taken", tt1, 1'b1); check("trap_st_ctrlrst", cr1, 1'b0);
    check("trap_st_mcause", mc1, 4'h2); check("trap_st_mtval", mt1, 32'hDEAD_BEEF);
    tick();
    idle(); fetchDecodeValid = 1; readAddress1 = 5'd9; readAddress2 = 5'd10;
    settle("tr3");
    check("trap_sb_empty_st", st2, 4'h0); check("trap_sb_empty_fl", fl2, 4'h0);
    check("trap_after_taken", tt1, 1'b0); check("trap_after_ctrlrst", cr1, 1'b0);
    check("trap_hold_mcause", mc1, 4'h2); check("trap_hold_mtval", mt1, 32'hDEAD_BEEF);
    do_reset();

    // Redirect merged with load-use, mret redirect, and x0 immunity.
    idle(); branchValid = 1; load(5'd5); fetchDecodeValid = 1; readAddress1 = 5'd5;
    settle("rd0");
    check("redir_lu_stall", st1, 4'h1); check("redir_lu_flush", fl1, 4'h3);
    tick();
    idle(); mretSignal = 1;
    settle("rd1");
    check("mret_flush", fl1, 4'h3); check("mret_stall", st1, 4'h0);
    tick();
    idle(); load(5'd0); fetchDecodeValid = 1;
    settle("rd2");
    check("x0_stall", st1, 4'h0); check("x0_flush", fl1, 4'h0);
    tick();
    idle(); fetchDecodeValid = 1;
    settle("rd3");
    check("x0_no_alloc", st1, 4'h0);
    do_reset();

    // Trap needs a valid writeback; reset during TRAP suppresses the trapTaken pulse.
    idle(); trapValid = 1; trapCause = 4'h7;
    settle("rt0");
    check("trap_nowb_ctrlrst", cr1, 1'b0); check("trap_nowb_flush", fl1, 4'h0);
    tick();
    idle(); trapValid = 1; memoryWritebackValid = 1; trapCause = 4'h7; trapValue = 32'h55;
    settle("rt1");
    check("trap2_ctrlrst", cr1, 1'b1);
    tick();
    reset = 1; idle();
    settle("rt2");
    check("rst_in_trap_taken", tt1, 1'b0); check("rst_in_trap_flush", fl1, 4'h0);
    tick();
    reset = 0; idle();
    settle("rt3");
    check("post_rst_taken", tt1, 1'b0); check("post_rst_flush", fl1, 4'h0);
    check("post_rst_mcause", mc1, 4'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
